// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - read-side hazard unit: tracks in-flight GRF writes in E/M/W,
// produces D-stage stall and per-operand forwarding selects.
module reg_scoreboard #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          freeze,
  input  logic [4:0]    issue_a3,
  input  logic [TW-1:0] issue_tnew,
  input  logic [4:0]    rs_addr,
  input  logic [TW-1:0] rs_tuse,
  input  logic [4:0]    rt_addr,
  input  logic [TW-1:0] rt_tuse,
  output logic          stall,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel
);

  localparam int LW = TW + 3;

  // Index 0 = E, 1 = M, 2 = W.
  logic [2:0]         valid_q, valid_d;
  logic [2:0][4:0]    a3_q, a3_d;
  logic [2:0][TW-1:0] tnew_q, tnew_d;

  logic          rs_hit, rt_hit;
  logic [1:0]    rs_sel, rt_sel;
  logic [TW-1:0] rs_tnew, rt_tnew;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  // Youngest matching stage wins; result packs {hit, sel, tnew}.
  function automatic logic [LW-1:0] lookup(input logic [4:0] addr);
    logic [LW-1:0] r;
    r = '0;
    if (addr == 5'd0) begin
      r = '0;
    end else if (valid_q[0] && a3_q[0] == addr) begin
      r = {1'b1, (tnew_q[0] == '0) ? 2'd1 : 2'd0, tnew_q[0]};
    end else if (valid_q[1] && a3_q[1] == addr) begin
      r = {1'b1, (tnew_q[1] == '0) ? 2'd2 : 2'd0, tnew_q[1]};
    end else if (valid_q[2] && a3_q[2] == addr) begin
      r = {1'b1, (tnew_q[2] == '0) ? 2'd3 : 2'd0, tnew_q[2]};
    end
    return r;
  endfunction

  assign {rs_hit, rs_sel, rs_tnew} = lookup(rs_addr);
  assign {rt_hit, rt_sel, rt_tnew} = lookup(rt_addr);

  assign stall      = (rs_hit && (rs_tnew > rs_tuse)) || (rt_hit && (rt_tnew > rt_tuse));
  assign fwd_rs_sel = rs_sel;
  assign fwd_rt_sel = rt_sel;

  always_comb begin
    valid_d = valid_q;
    a3_d    = a3_q;
    tnew_d  = tnew_q;
    if (!freeze) begin
      valid_d[2] = valid_q[1];
      a3_d[2]    = a3_q[1];
      tnew_d[2]  = sat_dec(tnew_q[1]);
      valid_d[1] = valid_q[0];
      a3_d[1]    = a3_q[0];
      tnew_d[1]  = sat_dec(tnew_q[0]);
      if (stall) begin
        valid_d[0] = 1'b0;
        a3_d[0]    = 5'd0;
        tnew_d[0]  = '0;
      end else begin
        valid_d[0] = (issue_a3 != 5'd0);
        a3_d[0]    = issue_a3;
        tnew_d[0]  = issue_tnew;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed and randomized checks of reg_scoreboard
// against an in-order pipeline model built from queues.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset, freeze;
  logic [4:0] issue_a3, rs_addr, rt_addr;
  logic [1:0] issue_tnew, rs_tuse, rt_tuse;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int a3;
    int tnew;
  } ent_t;

  // Front of the queue is the youngest in-flight instruction (E), back is W.
  ent_t pipe[$];

  always #5 clk = ~clk;

  reg_scoreboard #(.TW(2)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .issue_a3(issue_a3), .issue_tnew(issue_tnew),
    .rs_addr(rs_addr), .rs_tuse(rs_tuse),
    .rt_addr(rt_addr), .rt_tuse(rt_tuse),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  function automatic void look(input int addr, output bit hit, output int tn, output int sel);
    hit = 0; tn = 0; sel = 0;
    if (addr == 0) return;
    foreach (pipe[i]) begin
      if (pipe[i].v && pipe[i].a3 == addr) begin
        hit = 1;
        tn  = pipe[i].tnew;
        sel = (tn == 0) ? i + 1 : 0;
        return;
      end
    end
  endfunction

  function automatic bit model_stall();
    bit h1, h2;
    int t1, t2, s1, s2;
    look(int'(rs_addr), h1, t1, s1);
    look(int'(rt_addr), h2, t2, s2);
    return (h1 && t1 > int'(rs_tuse)) || (h2 && t2 > int'(rt_tuse));
  endfunction

  task automatic clear_model();
    ent_t e;
    e.v = 0; e.a3 = 0; e.tnew = 0;
    pipe.delete();
    repeat (3) pipe.push_back(e);
  endtask

  task automatic tick();
    bit   st;
    ent_t e;
    st = model_stall();
    if (reset) begin
      clear_model();
    end else if (!freeze) begin
      foreach (pipe[i]) if (pipe[i].tnew > 0) pipe[i].tnew--;
      e.v    = !st && (issue_a3 != 0);
      e.a3   = st ? 0 : int'(issue_a3);
      e.tnew = st ? 0 : int'(issue_tnew);
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 0; freeze = 0;
    issue_a3 = 0; issue_tnew = 0;
    rs_addr = 0; rs_tuse = 0; rt_addr = 0; rt_tuse = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    repeat (2) begin
      issue_a3 = 5'($urandom_range(1, 31)); issue_tnew = 2'($urandom);
      rs_addr = 5'($urandom); rt_addr = 5'($urandom);
      tick();
    end
    reset = 0;
    issue_a3 = 0;
    rs_addr = 5'd8; rt_addr = 5'd8; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL reset_rs_sel got %0d want 0", fwd_rs_sel); end
    checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL reset_rt_sel got %0d want 0", fwd_rt_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue_a3 = 5'd8; issue_tnew = 2'd1;
    tick();
    issue_a3 = 0; issue_tnew = 0;
    rs_addr = 5'd8; rs_tuse = 2'd0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_release got %b want 0", stall); end
    checks++; if (fwd_rs_sel !== 2'd2) begin errors++; $display("FAIL load_use_fwd got %0d want 2", fwd_rs_sel); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    issue_a3 = 5'd9; issue_tnew = 2'd0;
    tick();
    issue_a3 = 0;
    rt_addr = 5'd9; rt_tuse = 2'd1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall); end
    checks++; if (fwd_rt_sel !== 2'd1) begin errors++; $display("FAIL alu_fwd_e got %0d want 1", fwd_rt_sel); end
    tick();
    checks++; if (fwd_rt_sel !== 2'd2) begin errors++; $display("FAIL alu_fwd_m got %0d want 2", fwd_rt_sel); end
  endtask

  task automatic test_youngest();
    do_reset();
    issue_a3 = 5'd5; issue_tnew = 2'd0;
    repeat (3) tick();
    issue_a3 = 0;
    rs_addr = 5'd5; rt_addr = 5'd5; #1;
    checks++; if (fwd_rs_sel !== 2'd1) begin errors++; $display("FAIL youngest_rs got %0d want 1", fwd_rs_sel); end
    checks++; if (fwd_rt_sel !== 2'd1) begin errors++; $display("FAIL youngest_rt got %0d want 1", fwd_rt_sel); end
    tick();
    checks++; if (fwd_rs_sel !== 2'd2) begin errors++; $display("FAIL youngest_next got %0d want 2", fwd_rs_sel); end
  endtask

  task automatic test_zero_and_w();
    do_reset();
    issue_a3 = 5'd0; issue_tnew = 2'd2;
    tick();
    issue_tnew = 0;
    rs_addr = 0; rt_addr = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall got %b want 0", stall); end
    checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL zero_reg_sel got %0d want 0", fwd_rs_sel); end
    do_reset();
    issue_a3 = 5'd7;
    tick();
    issue_a3 = 0;
    repeat (2) tick();
    rs_addr = 5'd7; rt_addr = 5'd7; #1;
    checks++; if (fwd_rs_sel !== 2'd3) begin errors++; $display("FAIL w_fwd_rs got %0d want 3", fwd_rs_sel); end
    checks++; if (fwd_rt_sel !== 2'd3) begin errors++; $display("FAIL w_fwd_rt got %0d want 3", fwd_rt_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL w_fwd_stall got %b want 0", stall); end
    tick();
    checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL retired_sel got %0d want 0", fwd_rs_sel); end
  endtask

  task automatic test_freeze();
    do_reset();
    issue_a3 = 5'd4; issue_tnew = 2'd2;
    tick();
    issue_a3 = 0; issue_tnew = 0;
    rs_addr = 5'd4; rs_tuse = 0; freeze = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL freeze_stall c%0d got %b want 1", c, stall); end
      tick();
    end
    freeze = 0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL unfreeze0_stall got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL unfreeze1_stall got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unfreeze2_stall got %b want 0", stall); end
    checks++; if (fwd_rs_sel !== 2'd3) begin errors++; $display("FAIL unfreeze2_sel got %0d want 3", fwd_rs_sel); end
    issue_a3 = 5'd4; issue_tnew = 2'd2; rs_addr = 0;
    tick();
    issue_a3 = 0; issue_tnew = 0; rs_addr = 5'd4; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b want 1", stall); end
    reset = 1; freeze = 1;
    tick();
    reset = 0; freeze = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall got %b want 0", stall); end
    checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL reset_mid_sel got %0d want 0", fwd_rs_sel); end
  endtask

  task automatic test_random();
    bit h;
    int tn, exp_rs, exp_rt;
    bit exp_st;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      freeze     = ($urandom_range(0, 5) == 0);
      issue_a3   = 5'($urandom_range(0, 6));
      issue_tnew = 2'($urandom);
      rs_addr    = 5'($urandom_range(0, 6));
      rt_addr    = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 6));
      rs_tuse    = 2'($urandom);
      rt_tuse    = 2'($urandom);
      #1;
      look(int'(rs_addr), h, tn, exp_rs);
      look(int'(rt_addr), h, tn, exp_rt);
      exp_st = model_stall();
      checks++; if (stall !== exp_st) begin errors++; $display("FAIL rand_stall n%0d got %b want %b", n, stall, exp_st); end
      checks++; if (fwd_rs_sel !== 2'(exp_rs)) begin errors++; $display("FAIL rand_rs_sel n%0d got %0d want %0d", n, fwd_rs_sel, exp_rs); end
      checks++; if (fwd_rt_sel !== 2'(exp_rt)) begin errors++; $display("FAIL rand_rt_sel n%0d got %0d want %0d", n, fwd_rt_sel, exp_rt); end
      tick();
    end
  endtask

  initial begin
    clear_model();
    set_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_youngest();
    test_zero_and_w();
    test_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
